// File: rtl/uart_word_pkg.sv
// Shared word geometry and the TX sequencer state encoding for the UART word controller.
package uart_word_pkg;
  localparam int BYTES_PER_WORD = 8;
  localparam int WORD_W         = 64;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SEND    = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_word_asm.sv
// RX word assembler: big-endian byte shifter, inter-byte idle timeout and a one-deep
// holding register with a valid/ready output.
module uart_word_asm #(
  parameter int BYTES_PER_WORD = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [8*BYTES_PER_WORD-1:0] rx_word,
  output logic                        rx_word_valid,
  input  logic                        rx_word_ready,
  output logic [3:0]                  byte_cnt,
  output logic                        rx_overrun,
  output logic                        rx_timeout
);
  import uart_word_pkg::*;

  localparam int WORD_BITS = 8 * BYTES_PER_WORD;
  localparam int IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        LAST_CNT  = 4'(BYTES_PER_WORD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic                 handshake;

  always_comb begin
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;
    handshake    = hold_valid_q && rx_word_ready;

    if (handshake) hold_valid_d = 1'b0;

    if (rx_valid) begin
      // A byte always wins over a timeout landing on the same edge.
      shift_d = {shift_q[WORD_BITS-9:0], rx_data};
      idle_d  = '0;
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        if (!hold_valid_q || handshake) begin
          hold_d       = shift_d;
          hold_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (idle_q == IDLE_LAST) begin
        cnt_d     = '0;
        idle_d    = '0;
        shift_d   = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rx_word       = hold_q;
  assign rx_word_valid = hold_valid_q;
  assign byte_cnt      = cnt_q;
  assign rx_overrun    = overrun_q;
  assign rx_timeout    = timeout_q;
endmodule

// File: rtl/uart_word_ctrl.sv
// UART word controller: RX bytes assembled into words by uart_word_asm, TX words
// serialised MSB byte first against a byte UART's busy flag.
// Handshakes: a word moves on a rising clk edge where valid && ready; valid holds with
// stable data until then, and ready never depends combinationally on valid.
module uart_word_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int BYTES_PER_WORD = uart_word_pkg::BYTES_PER_WORD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [8*BYTES_PER_WORD-1:0] rx_word,
  output logic                        rx_word_valid,
  input  logic                        rx_word_ready,
  input  logic [8*BYTES_PER_WORD-1:0] tx_word,
  input  logic                        tx_word_valid,
  output logic                        tx_word_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [3:0]                  byte_cnt,
  output logic                        rx_overrun,
  output logic                        rx_timeout,
  output uart_word_pkg::tx_state_e    tx_state_dbg
);
  import uart_word_pkg::*;

  localparam int WORD_BITS = 8 * BYTES_PER_WORD;
  localparam int IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  uart_word_asm #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_word       (rx_word),
    .rx_word_valid (rx_word_valid),
    .rx_word_ready (rx_word_ready),
    .byte_cnt      (byte_cnt),
    .rx_overrun    (rx_overrun),
    .rx_timeout    (rx_timeout)
  );

  tx_state_e            state_q, state_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 ready_q, ready_d;

  // The latched word shifts left after each byte, so the current byte is always on top.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ready_d    = ready_q;
    unique case (state_q)
      TX_IDLE: begin
        ready_d = 1'b1;
        if (tx_word_valid && ready_q) begin
          word_d  = tx_word;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_data_d  = word_q[WORD_BITS-1 -: 8];
          tx_start_d = 1'b1;
          state_d    = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (tx_busy) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == IDX_LAST) begin
            ready_d = 1'b1;
            state_d = TX_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            word_d  = {word_q[WORD_BITS-9:0], 8'h00};
            state_d = TX_SEND;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_word_ready = ready_q;
  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign tx_state_dbg  = state_q;
endmodule

// File: doc/uart_word_ctrl.md
UART_WORD_CTRL -- requirements
Module: uart_word_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, inter-byte idle limit in clk cycles for a partial RX word.
REQ-002 Parameter BYTES_PER_WORD, default 8, bytes per word; word width is 8*BYTES_PER_WORD, 64 at default.
REQ-003 Ports: clk  in  1  system clock, all logic rising-edge.
REQ-004 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: rx_data  in  8  received UART byte; rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-006 Ports: rx_word  out  64  assembled word; rx_word_valid  out  1; rx_word_ready  in  1.
REQ-007 Ports: tx_word  in  64  word to send; tx_word_valid  in  1; tx_word_ready  out  1.
REQ-008 Ports: tx_data  out  8  byte to UART TX; tx_start  out  1  one-cycle send pulse; tx_busy  in  1  UART TX busy.
REQ-009 Ports: byte_cnt  out  4  RX bytes held; rx_overrun  out  1  pulse; rx_timeout  out  1  pulse.

Function
REQ-010 RX assembly: each rx_valid shifts rx_data in, first byte lands in rx_word[63:56], last byte in [7:0], big-endian.
REQ-011 byte_cnt increments per accepted byte, 0..7; the 8th byte copies the word to the holding register and resets byte_cnt to 0 on the same edge.
REQ-012 rx_word_valid rises the cycle after the 8th byte and holds, with rx_word stable, until rx_word_valid && rx_word_ready.
REQ-013 Assembly continues while the holding register is occupied; a word completing while it is still occupied is dropped, with rx_overrun pulsed for 1 cycle and the held word unchanged.
REQ-014 A word completing in the same cycle as the holding-register handshake is loaded, with no overrun.
REQ-015 Idle counter: cleared on every rx_valid; counts only while byte_cnt != 0.
REQ-016 When the idle counter reaches TIMEOUT_CYCLES, byte_cnt clears, rx_timeout pulses for 1 cycle and the partial bytes are discarded.
REQ-017 If rx_valid coincides with the timeout cycle, the byte is accepted and no timeout occurs.
REQ-018 TX FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
REQ-019 tx_word_ready = 1 only in IDLE; tx_word_valid && tx_word_ready latches tx_word, sets byte index 0 and goes to SEND.
REQ-020 SEND: when tx_busy = 0, drive tx_data = latched byte[index] (MSB byte first), pulse tx_start for 1 cycle and go to WAIT_HI; otherwise wait.
REQ-021 WAIT_HI: wait for tx_busy = 1, then go to WAIT_LO.
REQ-022 WAIT_LO: wait for tx_busy = 0; at index 7 go to IDLE, else increment the index and go to SEND.
REQ-023 tx_data holds its value from tx_start until the next tx_start.
REQ-024 RX and TX paths are independent; simultaneous activity has no interaction.
REQ-025 Throughput: one word per 8 UART byte times; controller overhead is ≤3 clk per byte.

Reset
REQ-026 rst_n low immediately sets: byte_cnt = 0, holding register empty, rx_word = 0, rx_word_valid = 0, idle counter = 0, rx_overrun = 0, rx_timeout = 0.
REQ-027 rst_n low immediately sets: TX state = IDLE, tx_word_ready = 0 while in reset and 1 on the first cycle after release, tx_start = 0, tx_data = 0, index = 0.
REQ-028 Reset mid-word or mid-transmission discards all partial data; there is no resume.

Structure
REQ-029 Package uart_word_pkg holds BYTES_PER_WORD, WORD_W = 64 and the TX state enum.
REQ-030 The RX assembler (shift register, byte_cnt, idle timer, holding register) is sub-module uart_word_asm; the TX FSM stays in the top level.

Verification
REQ-031 8 bytes 0x01..0x08 with rx_word_ready = 1 -> rx_word = 0x0102030405060708 and valid for 1 cycle.
REQ-032 3 bytes, then TIMEOUT_CYCLES idle -> rx_timeout pulse and byte_cnt = 0; next 8 bytes form a clean word.
REQ-033 rx_word_ready = 0 and 16 bytes -> first word held, rx_overrun pulses once, second word lost.
REQ-034 tx_word 0xA1B2C3D4E5F60718 with a UART model busy 10 cycles per byte -> 8 tx_start pulses carrying A1,B2,…,18 in order, then tx_word_ready = 1.
REQ-035 rst_n asserted after byte 4 of a TX word -> tx_start stops immediately and the FSM is in IDLE after release.
